// File: rtl/bcd_converter.sv
// bcd_converter: sequential double-dabble binary-to-BCD converter with a valid/ready input and held result
module bcd_converter #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_WIDTH-1:0]  bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  out_valid,
  output logic                  overflow
);
  localparam int WW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam logic [BIN_WIDTH-1:0] LIMIT = BIN_WIDTH'(10 ** DIGITS);
  localparam logic [BIN_WIDTH-1:0] SAT   = BIN_WIDTH'(10 ** DIGITS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  r_state, w_next_state;
  logic [WW-1:0]           r_work, w_adj;
  logic [BIN_WIDTH-1:0]    r_bin;
  logic [CW-1:0]           r_cnt;
  logic                    r_ovf;
  logic                    w_accept, w_done, w_sat;
  logic [WW+BIN_WIDTH-1:0] w_cat;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    assign w_adj[4*d+:4] = (r_work[4*d+:4] >= 4'd5) ? r_work[4*d+:4] + 4'd3 : r_work[4*d+:4];
  end

  // Work and binary registers shift as one; the binary MSB enters work bit 0.
  assign w_cat    = {w_adj, r_bin} << 1;
  assign w_sat    = bin >= LIMIT;
  assign in_ready = (r_state == IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next state, acceptance and completion decode
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    if (r_state == IDLE) begin
      w_accept     = in_valid;
      w_next_state = in_valid ? SHIFT : IDLE;
    end else begin
      w_done       = (r_cnt == CW'(1));
      w_next_state = w_done ? IDLE : SHIFT;
    end
  end

  // Datapath: load on acceptance, iterate in SHIFT, publish result only on the final iteration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_work    <= '0;
      r_bin     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      bcd       <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= w_done;
      if (w_accept) begin
        r_bin  <= w_sat ? SAT : bin;
        r_work <= '0;
        r_ovf  <= w_sat;
        r_cnt  <= CW'(BIN_WIDTH);
      end else if (r_state == SHIFT) begin
        r_work <= w_cat[WW+BIN_WIDTH-1:BIN_WIDTH];
        r_bin  <= w_cat[BIN_WIDTH-1:0];
        r_cnt  <= r_cnt - 1'b1;
      end
      if (w_done) begin
        bcd      <= w_cat[WW+BIN_WIDTH-1:BIN_WIDTH];
        overflow <= r_ovf;
      end
    end
  end
endmodule
